scfifo_param_thresh: RTL and testbench
======================================

SCFIFO_PARAM_THRESH -- requirements
Module: scfifo_param_thresh

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 80, bits per entry (1..512).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 64, number of entries (power of two, 4..4096).
REQ-003 The block SHALL have parameter AF_THRESH, default 56, almost-full level (1..FIFO_DEPTH-1).
REQ-004 The block SHALL have parameter AE_THRESH, default 8, almost-empty level (0..FIFO_DEPTH-2, below AF_THRESH).
REQ-005 The block SHALL have parameter FWFT, default 1, read mode (1 = first-word-fall-through, 0 = registered pop).
REQ-006 The block SHALL have CW = log2(FIFO_DEPTH)+1 as the derived count width.
REQ-007 iClock  in  1  single clock; all logic is rising-edge.
REQ-008 iReset  in  1  asynchronous, active-high reset.
REQ-009 iPushData  in  DATA_WIDTH  write data.
REQ-010 iPushEnable  in  1  push request.
REQ-011 oIsFull  out  1  count == FIFO_DEPTH.
REQ-012 oIsAlmostFull  out  1  count >= AF_THRESH.
REQ-013 oPopData  out  DATA_WIDTH  read data.
REQ-014 iPopEnable  in  1  pop request.
REQ-015 oIsEmpty  out  1  count == 0.
REQ-016 oIsAlmostEmpty  out  1  count <= AE_THRESH.
REQ-017 oDataCount  out  CW  current occupancy, full width, not truncated (0..FIFO_DEPTH).
REQ-018 oOverflow  out  1  sticky: a push was attempted while full.
REQ-019 oUnderflow  out  1  sticky: a pop was attempted while empty.
REQ-020 iClearFlags  in  1  clears oOverflow and oUnderflow.

Function
REQ-021 A push SHALL be accepted iff iPushEnable=1 and oIsFull=0; the write pointer advances modulo FIFO_DEPTH.
REQ-022 A pop SHALL be accepted iff iPopEnable=1 and oIsEmpty=0; the read pointer advances modulo FIFO_DEPTH.
REQ-023 A push while full SHALL be dropped even if a pop is accepted in the same cycle.
REQ-024 In a cycle with an accepted push and an accepted pop, the count SHALL be unchanged; with push only, +1; with pop only, -1.
REQ-025 When empty with push and pop both requested, the push SHALL be accepted, the pop rejected, and underflow set.
REQ-026 oDataCount, oIsFull, oIsEmpty, oIsAlmostFull and oIsAlmostEmpty SHALL be registered and reflect the accepted operations of the previous edge; there is no combinational path from any input to them.
REQ-027 With FWFT=1, oPopData SHALL present the head entry whenever oIsEmpty=0, with first data visible the cycle after the first push, and SHALL advance to the next entry the cycle after an accepted pop.
REQ-028 With FWFT=0, oPopData SHALL be a register loaded with the head entry on the edge of an accepted pop (data valid the cycle after the pop), holding its value otherwise.
REQ-029 With FWFT=1 and oIsEmpty=1, oPopData SHALL hold its last value.
REQ-030 oOverflow SHALL be set on a rejected push request and oUnderflow on a rejected pop request; both SHALL hold until iClearFlags=1.
REQ-031 When a set and iClearFlags occur in the same cycle, the set SHALL win.
REQ-032 Pointer wrap SHALL be seamless: ordering is preserved across any number of wraps.

Reset
REQ-033 While iReset=1, regardless of clock: pointers=0, oDataCount=0, oIsEmpty=1, oIsAlmostEmpty=1, oIsFull=0, oIsAlmostFull=0, oOverflow=0, oUnderflow=0, oPopData=0.
REQ-034 Reset asserted mid-operation SHALL discard all contents; memory array contents need not be cleared.
REQ-035 The first push SHALL be accepted on the first rising edge after iReset deasserts.

Verification
REQ-036 Defaults; push 64 words 0..63 -> oDataCount 0,1,..,64; oIsAlmostFull rises at count 56; oIsFull=1 at 64; 65th push -> oOverflow=1, count stays 64.
REQ-037 Pop all 64 words (FWFT=1) -> data 0..63 in order; oIsAlmostEmpty=1 at count 8; oIsEmpty=1 at 0; further pop -> oUnderflow=1; iClearFlags -> both flags 0.
REQ-038 Count at 10, simultaneous push/pop for 200 cycles -> count stays 10, data in order across 3+ pointer wraps.
REQ-039 Full with push+pop same cycle -> pop accepted, push dropped, oOverflow=1, count 63; empty with push+pop -> count 1, oUnderflow=1.
REQ-040 FWFT=0, DATA_WIDTH=16, FIFO_DEPTH=8: push A,B; pop -> oPopData=A one cycle later, holds; pop -> B.
REQ-041 iReset pulsed asynchronously between edges at count 20 with flags set -> all outputs at reset values immediately; next push then pop returns the new word.

Source files
------------

// File: rtl/scfifo_param_thresh_if.sv
// Handshake/status bundle for scfifo_param_thresh. The master drives push/pop
// requests and the slave (the FIFO) returns data, occupancy and status flags.
interface scfifo_param_thresh_if #(
    parameter int DATA_WIDTH = 80,
    parameter int FIFO_DEPTH = 64
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // A push is taken when iPushEnable=1 and oIsFull=0; a pop is taken when
    // iPopEnable=1 and oIsEmpty=0. Rejected requests raise sticky flags.
    logic [DATA_WIDTH-1:0] iPushData;
    logic                  iPushEnable;
    logic                  iPopEnable;
    logic                  iClearFlags;
    logic [DATA_WIDTH-1:0] oPopData;
    logic                  oIsFull;
    logic                  oIsAlmostFull;
    logic                  oIsEmpty;
    logic                  oIsAlmostEmpty;
    logic [CW-1:0]         oDataCount;
    logic                  oOverflow;
    logic                  oUnderflow;

    modport master (
        output iPushData, iPushEnable, iPopEnable, iClearFlags,
        input  oPopData, oIsFull, oIsAlmostFull, oIsEmpty, oIsAlmostEmpty,
               oDataCount, oOverflow, oUnderflow
    );

    modport slave (
        input  iPushData, iPushEnable, iPopEnable, iClearFlags,
        output oPopData, oIsFull, oIsAlmostFull, oIsEmpty, oIsAlmostEmpty,
               oDataCount, oOverflow, oUnderflow
    );
endinterface

// File: rtl/scfifo_param_thresh.sv
// Single-clock FIFO with registered occupancy, almost-full/empty thresholds,
// sticky overflow/underflow flags and selectable FWFT or registered-pop read.
module scfifo_param_thresh #(
    parameter int DATA_WIDTH = 80,
    parameter int FIFO_DEPTH = 64,
    parameter int AF_THRESH  = 56,
    parameter int AE_THRESH  = 8,
    parameter int FWFT       = 1
) (
    input logic                  iClock,
    input logic                  iReset,
    scfifo_param_thresh_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] pop_data_q, pop_data_d;
    logic                  push_ok, pop_ok;

    always_comb begin
        push_ok  = bus.iPushEnable && !full_q;
        pop_ok   = bus.iPopEnable && !empty_q;
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d   = (count_d == CW'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= CW'(AF_THRESH));
        aempty_d = (count_d <= CW'(AE_THRESH));
        // A set in the same cycle as a clear takes priority.
        ovf_d    = (bus.iPushEnable && full_q) || (ovf_q && !bus.iClearFlags);
        unf_d    = (bus.iPopEnable && empty_q) || (unf_q && !bus.iClearFlags);

        pop_data_d = pop_data_q;
        if (FWFT != 0) begin
            // Preload the next head; if the only remaining word is the one
            // being pushed now, take it straight from the write port.
            if (!empty_d) begin
                if (count_q == CW'(pop_ok))
                    pop_data_d = bus.iPushData;
                else
                    pop_data_d = mem[rd_ptr_d];
            end
        end else if (pop_ok) begin
            pop_data_d = mem[rd_ptr_q];
        end
    end

    always_ff @(posedge iClock) begin
        if (push_ok && !iReset)
            mem[wr_ptr_q] <= bus.iPushData;
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            pop_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            afull_q    <= afull_d;
            aempty_q   <= aempty_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            pop_data_q <= pop_data_d;
        end
    end

    assign bus.oPopData       = pop_data_q;
    assign bus.oIsFull        = full_q;
    assign bus.oIsAlmostFull  = afull_q;
    assign bus.oIsEmpty       = empty_q;
    assign bus.oIsAlmostEmpty = aempty_q;
    assign bus.oDataCount     = count_q;
    assign bus.oOverflow      = ovf_q;
    assign bus.oUnderflow     = unf_q;
endmodule

// File: tb/tb_scfifo_param_thresh.sv
// Bench for scfifo_param_thresh: a default FWFT instance and a small
// registered-pop instance, each checked against a queue-based reference model.
module tb_scfifo_param_thresh;
    logic iClock = 1'b0;
    logic iReset = 1'b1;

    always #5 iClock = ~iClock;

    scfifo_param_thresh_if #(.DATA_WIDTH(80), .FIFO_DEPTH(64)) if0 ();
    scfifo_param_thresh_if #(.DATA_WIDTH(16), .FIFO_DEPTH(8))  if1 ();

    scfifo_param_thresh dut0 (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (if0)
    );

    scfifo_param_thresh #(
        .DATA_WIDTH (16),
        .FIFO_DEPTH (8),
        .AF_THRESH  (6),
        .AE_THRESH  (1),
        .FWFT       (0)
    ) dut1 (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (if1)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int step_no = 0;

    // Reference models: a queue of stored words, sticky flags and expected read data.
    logic [79:0] q0[$];
    logic [79:0] d0_exp;
    bit          ovf0, unf0;
    logic [15:0] q1[$];
    logic [15:0] d1_exp;
    bit          ovf1, unf1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        if0.iPushData = '0; if0.iPushEnable = 1'b0; if0.iPopEnable = 1'b0; if0.iClearFlags = 1'b0;
        if1.iPushData = '0; if1.iPushEnable = 1'b0; if1.iPopEnable = 1'b0; if1.iClearFlags = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_count0", if0.oDataCount, 0);
        check("rst_empty0", if0.oIsEmpty, 1);
        check("rst_aempty0", if0.oIsAlmostEmpty, 1);
        check("rst_full0", if0.oIsFull, 0);
        check("rst_afull0", if0.oIsAlmostFull, 0);
        check("rst_ovf0", if0.oOverflow, 0);
        check("rst_unf0", if0.oUnderflow, 0);
        check("rst_data0", if0.oPopData, 0);
        check("rst_count1", if1.oDataCount, 0);
        check("rst_empty1", if1.oIsEmpty, 1);
        check("rst_ovf1", if1.oOverflow, 0);
        check("rst_unf1", if1.oUnderflow, 0);
        check("rst_data1", if1.oPopData, 0);
    endtask

    task automatic clear_models();
        q0.delete(); d0_exp = '0; ovf0 = 0; unf0 = 0;
        q1.delete(); d1_exp = '0; ovf1 = 0; unf1 = 0;
    endtask

    // One clock on the default FWFT instance; model follows the accept rules.
    task automatic step0(input bit push, input logic [79:0] data, input bit pop, input bit clr);
        bit push_acc, pop_acc;
        int n;
        if0.iPushEnable = push; if0.iPushData = data; if0.iPopEnable = pop; if0.iClearFlags = clr;
        @(posedge iClock);
        step_no++;
        push_acc = push && (q0.size() < 64);
        pop_acc  = pop && (q0.size() != 0);
        if (push && !push_acc) ovf0 = 1; else if (clr) ovf0 = 0;
        if (pop && !pop_acc)   unf0 = 1; else if (clr) unf0 = 0;
        if (pop_acc) void'(q0.pop_front());
        if (push_acc) q0.push_back(data);
        if (q0.size() != 0) d0_exp = q0[0];
        n = q0.size();
        #1;
        check("count0", if0.oDataCount, n);
        check("full0", if0.oIsFull, n == 64);
        check("empty0", if0.oIsEmpty, n == 0);
        check("afull0", if0.oIsAlmostFull, n >= 56);
        check("aempty0", if0.oIsAlmostEmpty, n <= 8);
        check("ovf0", if0.oOverflow, ovf0);
        check("unf0", if0.oUnderflow, unf0);
        check("data0", if0.oPopData, d0_exp);
    endtask

    // One clock on the small registered-pop instance.
    task automatic step1(input bit push, input logic [15:0] data, input bit pop, input bit clr);
        bit push_acc, pop_acc;
        int n;
        if1.iPushEnable = push; if1.iPushData = data; if1.iPopEnable = pop; if1.iClearFlags = clr;
        @(posedge iClock);
        step_no++;
        push_acc = push && (q1.size() < 8);
        pop_acc  = pop && (q1.size() != 0);
        if (push && !push_acc) ovf1 = 1; else if (clr) ovf1 = 0;
        if (pop && !pop_acc)   unf1 = 1; else if (clr) unf1 = 0;
        if (pop_acc) d1_exp = q1.pop_front();
        if (push_acc) q1.push_back(data);
        n = q1.size();
        #1;
        check("count1", if1.oDataCount, n);
        check("full1", if1.oIsFull, n == 8);
        check("empty1", if1.oIsEmpty, n == 0);
        check("afull1", if1.oIsAlmostFull, n >= 6);
        check("aempty1", if1.oIsAlmostEmpty, n <= 1);
        check("ovf1", if1.oOverflow, ovf1);
        check("unf1", if1.oUnderflow, unf1);
        check("data1", if1.oPopData, d1_exp);
    endtask

    function automatic logic [79:0] rand80();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    initial begin
        idle_inputs();
        clear_models();
        iReset = 1'b1;
        repeat (3) @(posedge iClock);
        #1;
        check_reset_values();
        @(negedge iClock);
        iReset = 1'b0;

        // Fill 0..63, then one push too many.
        for (int i = 0; i < 64; i++) step0(1, 80'(i), 0, 0);
        step0(1, 80'hDEAD, 0, 0);
        step0(0, 0, 0, 1);

        // Drain in order, then one pop too many, then clear.
        for (int i = 0; i < 64; i++) step0(0, 0, 1, 0);
        step0(0, 0, 1, 0);
        step0(0, 0, 0, 1);

        // Hold occupancy at 10 across several pointer wraps.
        for (int i = 0; i < 10; i++) step0(1, rand80(), 0, 0);
        for (int i = 0; i < 200; i++) step0(1, rand80(), 1, 0);

        // Push+pop while full, then push+pop while empty.
        while (q0.size() < 64) step0(1, rand80(), 0, 0);
        step0(1, rand80(), 1, 0);
        while (q0.size() > 0) step0(0, 0, 1, 0);
        step0(1, rand80(), 1, 1);
        step0(0, 0, 1, 1);

        // Random traffic, fill-biased then drain-biased.
        for (int i = 0; i < 300; i++) begin
            step0($urandom_range(0, 99) < (i < 150 ? 75 : 30), rand80(),
                  $urandom_range(0, 99) < (i < 150 ? 30 : 75), $urandom_range(0, 15) == 0);
        end

        // Reach count 20 with both sticky flags set, then pulse reset between edges.
        while (q0.size() > 0) step0(0, 0, 1, 0);
        step0(0, 0, 1, 0);
        while (q0.size() < 64) step0(1, rand80(), 0, 0);
        step0(1, rand80(), 0, 0);
        for (int i = 0; i < 44; i++) step0(0, 0, 1, 0);
        idle_inputs();
        #2;
        iReset = 1'b1;
        #1;
        check_reset_values();
        iReset = 1'b0;
        clear_models();
        step0(1, 80'h1234_5678_9ABC_DEF0_1357, 0, 0);
        step0(0, 0, 1, 0);
        step0(0, 0, 0, 0);

        // Registered-pop instance: A, B, pop, hold, pop.
        step1(1, 16'hA5A5, 0, 0);
        step1(1, 16'hB6B6, 0, 0);
        step1(0, 0, 1, 0);
        step1(0, 0, 0, 0);
        step1(0, 0, 1, 0);
        step1(0, 0, 1, 0);
        for (int i = 0; i < 200; i++) begin
            step1($urandom_range(0, 99) < (i < 100 ? 70 : 35), 16'($urandom()),
                  $urandom_range(0, 99) < (i < 100 ? 35 : 70), $urandom_range(0, 11) == 0);
        end

        idle_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
